// File: rtl/cos_proj_pkg.sv
// rtl/cos_proj_pkg.sv - shared constants and helpers for the cosine projection accumulator
//
// Purpose: default cosine table length, Q-format helper, saturation limits and
//          the cosine table entry generator used by cos_rom_multiport.
// Ports:   none (package).

package cos_proj_pkg;

    localparam int  COS_TABLE_LEN = 512;
    localparam real COS_PI        = 3.14159265358979323846;

    // Cosine samples are signed Q2.(bw-2): 1.0 is 2^(bw-2).
    function automatic int q_frac_bits(input int bw);
        return bw - 2;
    endfunction

    function automatic logic signed [63:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    // Entry idx of a full-period table of tlen points, rounded to nearest.
    function automatic logic signed [63:0] cos_entry(input int idx, input int bw, input int tlen);
        real ang;
        ang = 2.0 * COS_PI * real'(idx) / real'(tlen);
        return longint'($cos(ang) * (2.0 ** q_frac_bits(bw)));
    endfunction

endpackage

// File: rtl/cos_rom_multiport.sv
// rtl/cos_rom_multiport.sv - single cosine table with several registered read ports
//
// Purpose: one full-period cosine table, NUM_PORTS independent reads, 1-cycle latency.
// Ports:   clk_in  - clock
//          i_addr  - packed read addresses, port p at [p*TW +: TW]
//          o_data  - packed registered table values, port p at [p*BIT_WIDTH +: BIT_WIDTH]

module cos_rom_multiport
    import cos_proj_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_PORTS = 3,
    parameter int TABLE_LEN = COS_TABLE_LEN
) (
    input  logic                                   clk_in,
    input  logic [NUM_PORTS*$clog2(TABLE_LEN)-1:0] i_addr,
    output logic [NUM_PORTS*BIT_WIDTH-1:0]         o_data
);

    localparam int TW = $clog2(TABLE_LEN);

    logic [BIT_WIDTH-1:0] w_table [TABLE_LEN];
    logic [BIT_WIDTH-1:0] r_data  [NUM_PORTS];

    for (genvar i = 0; i < TABLE_LEN; i++) begin : g_entry
        assign w_table[i] = BIT_WIDTH'(cos_entry(i, BIT_WIDTH, TABLE_LEN));
    end

    always_ff @(posedge clk_in) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            r_data[p] <= w_table[i_addr[p*TW +: TW]];
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign o_data[p*BIT_WIDTH +: BIT_WIDTH] = r_data[p];
    end

endmodule

// File: rtl/cos_proj_accum.sv
// rtl/cos_proj_accum.sv - per-frame running cosine projections of a sample stream
//
// Purpose: for each channel n, outputs the prefix sum over the frame of
//          (sample * cos(2*pi*n*k/TABLE_LEN)) scaled down, 3 cycles after each
//          accepted sample. Pipeline: ROM read -> multiply -> accumulate.
// Ports:   clk_in, rst_in      - clock, synchronous active-high reset
//          in_valid, in_data   - sample stream (signed)
//          frame_abort         - drop current frame; a same-cycle sample starts a new one
//          out_sums            - packed signed prefix sums, channel n at [n*BIT_WIDTH +: BIT_WIDTH]
//          out_valid, out_addr - output strobe and sample index k
//          frame_done          - pulse with the output for k = FRAME_LEN-1
//          overflow            - per-channel sticky signed-overflow flags for the frame
// Build option: define COS_PROJ_ACCUM_SAT_EN to saturate accumulator additions
//               (default build wraps two's-complement).

module cos_proj_accum
    import cos_proj_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int FRAME_LEN   = 160,
    parameter int NUM_NU      = 3,
    parameter int TABLE_LEN   = COS_TABLE_LEN,
    parameter int SCALE_SHIFT = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          in_valid,
    input  logic [BIT_WIDTH-1:0]          in_data,
    input  logic                          frame_abort,
    output logic [NUM_NU*BIT_WIDTH-1:0]   out_sums,
    output logic                          out_valid,
    output logic [$clog2(FRAME_LEN)-1:0]  out_addr,
    output logic                          frame_done,
    output logic [NUM_NU-1:0]             overflow
);

    localparam int            AW     = $clog2(FRAME_LEN);
    localparam int            TW     = $clog2(TABLE_LEN);
    localparam int            PSHIFT = q_frac_bits(BIT_WIDTH) + SCALE_SHIFT;
    localparam logic [AW-1:0] LAST_K = AW'(FRAME_LEN - 1);

`ifdef COS_PROJ_ACCUM_SAT_EN
    localparam logic signed [63:0] LP_MAX = sat_max(BIT_WIDTH);
    localparam logic signed [63:0] LP_MIN = sat_min(BIT_WIDTH);
`endif

    // Stage 0: sample index and table addresses
    logic [AW-1:0]           r_k;
    logic [AW-1:0]           w_k_cur;
    logic [NUM_NU*TW-1:0]    w_rom_addr;
    logic [NUM_NU*BIT_WIDTH-1:0] w_cos;

    // Stage 1: ROM output alongside the sample
    logic                    r_s1_valid;
    logic [AW-1:0]           r_s1_k;
    logic [BIT_WIDTH-1:0]    r_s1_data;

    // Stage 2: scaled products
    logic                    r_s2_valid;
    logic [AW-1:0]           r_s2_k;
    logic [BIT_WIDTH-1:0]    r_prod [NUM_NU];
    logic [BIT_WIDTH-1:0]    w_prod [NUM_NU];

    // Stage 3: accumulators and outputs
    logic [BIT_WIDTH-1:0]    r_acc      [NUM_NU];
    logic [BIT_WIDTH-1:0]    w_acc_next [NUM_NU];
    logic [NUM_NU-1:0]       w_add_ovf;
    logic [NUM_NU-1:0]       r_ovf;
    logic                    r_out_valid;
    logic [AW-1:0]           r_out_addr;
    logic                    r_frame_done;
    logic                    w_first;

    // An abort restarts numbering, so a sample arriving with it is k = 0.
    assign w_k_cur = frame_abort ? '0 : r_k;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_k <= '0;
        end else if (in_valid) begin
            r_k <= (w_k_cur == LAST_K) ? '0 : w_k_cur + AW'(1);
        end else if (frame_abort) begin
            r_k <= '0;
        end
    end

    cos_rom_multiport #(
        .BIT_WIDTH (BIT_WIDTH),
        .NUM_PORTS (NUM_NU),
        .TABLE_LEN (TABLE_LEN)
    ) u_rom (
        .clk_in (clk_in),
        .i_addr (w_rom_addr),
        .o_data (w_cos)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
        end
        r_s1_k    <= w_k_cur;
        r_s1_data <= in_data;
    end

    // Samples already in flight belong to the aborted frame and are dropped here.
    always_ff @(posedge clk_in) begin
        if (rst_in || frame_abort) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
        end
        r_s2_k <= r_s1_k;
        for (int n = 0; n < NUM_NU; n++) begin
            r_prod[n] <= w_prod[n];
        end
    end

    assign w_first = (r_s2_k == '0);

    for (genvar n = 0; n < NUM_NU; n++) begin : g_chan
        logic signed [2*BIT_WIDTH-1:0] w_full;
        logic [BIT_WIDTH-1:0]          w_base;
        logic [BIT_WIDTH-1:0]          w_sum;

        // Table index is n*k mod TABLE_LEN; TABLE_LEN is a power of two.
        assign w_rom_addr[n*TW +: TW] = TW'(n * int'(w_k_cur));

        assign w_full = (2*BIT_WIDTH)'($signed(r_s1_data))
                      * (2*BIT_WIDTH)'($signed(w_cos[n*BIT_WIDTH +: BIT_WIDTH]));
        assign w_prod[n] = BIT_WIDTH'(w_full >>> PSHIFT);

        // The first sample of a frame starts from zero, which also restarts the frame.
        assign w_base = w_first ? '0 : r_acc[n];
        assign w_sum  = w_base + r_prod[n];

        // Signed overflow: both addends share a sign that the sum does not.
        assign w_add_ovf[n] = (w_base[BIT_WIDTH-1] == r_prod[n][BIT_WIDTH-1])
                           && (w_sum[BIT_WIDTH-1]  != r_prod[n][BIT_WIDTH-1]);

`ifdef COS_PROJ_ACCUM_SAT_EN
        assign w_acc_next[n] = !w_add_ovf[n]             ? w_sum :
                               r_prod[n][BIT_WIDTH-1]    ? LP_MIN[BIT_WIDTH-1:0] :
                                                           LP_MAX[BIT_WIDTH-1:0];
`else
        assign w_acc_next[n] = w_sum;
`endif

        assign out_sums[n*BIT_WIDTH +: BIT_WIDTH] = r_out_valid ? r_acc[n] : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || frame_abort) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_addr   <= '0;
            r_ovf        <= '0;
            for (int n = 0; n < NUM_NU; n++) begin
                r_acc[n] <= '0;
            end
        end else begin
            r_out_valid  <= r_s2_valid;
            r_frame_done <= r_s2_valid && (r_s2_k == LAST_K);
            r_out_addr   <= r_s2_valid ? r_s2_k : '0;
            for (int n = 0; n < NUM_NU; n++) begin
                if (r_s2_valid) begin
                    r_acc[n] <= w_acc_next[n];
                    r_ovf[n] <= w_add_ovf[n] | (r_ovf[n] & ~w_first);
                end else if (r_frame_done) begin
                    r_acc[n] <= '0;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    assign frame_done = r_frame_done;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_cos_proj_accum.sv
// tb/tb_cos_proj_accum.sv - scoreboard bench for cos_proj_accum

module tb_cos_proj_accum;

    localparam int     BW   = 32;
    localparam int     FL   = 160;
    localparam int     NN   = 3;
    localparam int     TL   = 512;
    localparam int     SS   = 4;
    localparam real    PI   = 3.14159265358979323846;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, vld, abort;
    logic [31:0]   data;
    logic [95:0]   sums;
    logic          ov, done;
    logic [7:0]    addr;
    logic [2:0]    ovf;

    logic          rst_b, vld_b, abort_b;
    logic [31:0]   data_b;
    logic [95:0]   sums_b;
    logic          ov_b, done_b;
    logic [7:0]    addr_b;
    logic [2:0]    ovf_b;

    cos_proj_accum #(.BIT_WIDTH(BW), .FRAME_LEN(FL), .NUM_NU(NN), .TABLE_LEN(TL), .SCALE_SHIFT(SS)) dut (
        .clk_in(clk), .rst_in(rst), .in_valid(vld), .in_data(data), .frame_abort(abort),
        .out_sums(sums), .out_valid(ov), .out_addr(addr), .frame_done(done), .overflow(ovf)
    );

    cos_proj_accum #(.BIT_WIDTH(BW), .FRAME_LEN(FL), .NUM_NU(NN), .TABLE_LEN(TL), .SCALE_SHIFT(0)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .in_valid(vld_b), .in_data(data_b), .frame_abort(abort_b),
        .out_sums(sums_b), .out_valid(ov_b), .out_addr(addr_b), .frame_done(done_b), .overflow(ovf_b)
    );

    typedef struct {
        int          addr;
        logic [95:0] sums;
        logic        done;
        logic [2:0]  ovf;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    longint      cos_tab [TL];
    logic [31:0] m_acc [NN];
    logic [2:0]  m_ovf;
    int          m_k;
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            n_vec++;
            if (ov === 1'b1) begin
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: out_valid=1 out_addr=%0d, required no output", addr);
                end else begin
                    mon_e = q.pop_front();
                    if (addr !== 8'(mon_e.addr) || sums !== mon_e.sums || done !== mon_e.done || ovf !== mon_e.ovf) begin
                        n_err++;
                        $display("FAIL sb_out: got addr=%0d sums=%h done=%b ovf=%b, required addr=%0d sums=%h done=%b ovf=%b",
                                 addr, sums, done, ovf, mon_e.addr, mon_e.sums, mon_e.done, mon_e.ovf);
                    end
                end
            end else if (ov !== 1'b0 || sums !== '0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL sb_idle: got out_valid=%b sums=%h done=%b, required 0/0/0", ov, sums, done);
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit ab);
        exp_t               e;
        logic signed [63:0] p;
        logic [31:0]        p32, base;
        longint             ex;
        bit                 o;
        if (ab) m_k = 0;
        e.addr = m_k;
        e.done = (m_k == FL - 1);
        e.sums = '0;
        for (int n = 0; n < NN; n++) begin
            p    = (longint'($signed(d)) * cos_tab[(n * m_k) % TL]) >>> (BW - 2 + SS);
            p32  = p[31:0];
            base = (m_k == 0) ? 32'd0 : m_acc[n];
            ex   = longint'($signed(base)) + longint'($signed(p32));
            o    = (ex > MAXV) || (ex < MINV);
`ifdef COS_PROJ_ACCUM_SAT_EN
            if (ex > MAXV)      m_acc[n] = 32'h7FFFFFFF;
            else if (ex < MINV) m_acc[n] = 32'h80000000;
            else                m_acc[n] = ex[31:0];
`else
            m_acc[n] = ex[31:0];
`endif
            m_ovf[n] = o | ((m_k == 0) ? 1'b0 : m_ovf[n]);
            e.sums[n*32 +: 32] = m_acc[n];
        end
        e.ovf = m_ovf;
        q.push_back(e);
        m_k = (m_k == FL - 1) ? 0 : m_k + 1;
        vld = 1'b1; data = d; abort = ab;
        @(posedge clk); #1;
        vld = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b0; abort = 1'b0; data = '0;
        rst_b = 1'b1; vld_b = 1'b0; abort_b = 1'b0; data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec += 6;
        if (ov !== 1'b0)   begin n_err++; $display("FAIL rst_valid: got %b, required 0", ov); end
        if (sums !== '0)   begin n_err++; $display("FAIL rst_sums: got %h, required 0", sums); end
        if (addr !== 8'd0) begin n_err++; $display("FAIL rst_addr: got %0d, required 0", addr); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, required 0", done); end
        if (ovf !== 3'b0)  begin n_err++; $display("FAIL rst_ovf: got %b, required 000", ovf); end
        if (ov_b !== 1'b0) begin n_err++; $display("FAIL rst_valid_b: got %b, required 0", ov_b); end
        rst = 1'b0; rst_b = 1'b0;
        m_k = 0; m_ovf = '0;
        mon_on = 1'b1;
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < FL; i++) send(32'd65536, 1'b0);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL frame_done_early1: got %b, required 0", done); end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL frame_done_early2: got %b, required 0", done); end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b1 || addr !== 8'd159 || sums[31:0] !== 32'd655360) begin
            n_err++;
            $display("FAIL frame_last: got done=%b addr=%0d ch0=%0d, required 1/159/655360", done, addr, sums[31:0]);
        end
        for (int i = 0; i < 16 && q.size() != 0; i++) @(posedge clk);
        #1; n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL frame_drain: %0d outputs missing, required 0", q.size()); end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 41; i++) send(32'd65536, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk); #1;
            if (j >= 3) begin
                n_vec++;
                if (ov !== 1'b0) begin n_err++; $display("FAIL gap_valid: got %b in gap cycle %0d, required 0", ov, j); end
            end
        end
        for (int i = 0; i < FL - 41; i++) send(32'd65536, 1'b0);
        for (int i = 0; i < 16 && q.size() != 0; i++) @(posedge clk);
        #1; n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL gap_drain: %0d outputs missing, required 0", q.size()); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 80; i++) send(32'd65536, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        send(32'd65536, 1'b1);
        n_vec++;
        if (ov !== 1'b0) begin n_err++; $display("FAIL abort_k78: got out_valid=%b, required 0", ov); end
        @(posedge clk); #1;
        n_vec++;
        if (ov !== 1'b0) begin n_err++; $display("FAIL abort_k79: got out_valid=%b, required 0", ov); end
        @(posedge clk); #1;
        n_vec++;
        if (ov !== 1'b1 || addr !== 8'd0 || sums[31:0] !== 32'd4096 || ovf !== 3'b0) begin
            n_err++;
            $display("FAIL abort_new: got valid=%b addr=%0d ch0=%0d ovf=%b, required 1/0/4096/000", ov, addr, sums[31:0], ovf);
        end
        for (int i = 0; i < 5; i++) send(32'd65536, 1'b0);
        for (int i = 0; i < 16 && q.size() != 0; i++) @(posedge clk);
        #1; n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL abort_drain: %0d outputs missing, required 0", q.size()); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        m_k = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i < FL) d = 32'h7FF00000 | ($urandom & 32'h0000FFFF);
            else        d = 32'($urandom_range(0, 131071)) - 32'd65536;
            send(d, 1'b0);
        end
        for (int i = 0; i < 16 && q.size() != 0; i++) @(posedge clk);
        #1; n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL b2b_drain: %0d outputs missing, required 0", q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 100; i++) send(32'd65536, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (ov !== 1'b0 || sums !== '0 || done !== 1'b0 || addr !== 8'd0 || ovf !== 3'b0) begin
            n_err++;
            $display("FAIL rstmid_out: got valid=%b sums=%h done=%b addr=%0d ovf=%b, required all 0", ov, sums, done, addr, ovf);
        end
        rst = 1'b0;
        m_k = 0;
        send(32'd65536, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if (ov !== 1'b1 || addr !== 8'd0 || sums[31:0] !== 32'd4096) begin
            n_err++;
            $display("FAIL rstmid_next: got valid=%b addr=%0d ch0=%0d, required 1/0/4096", ov, addr, sums[31:0]);
        end
        for (int i = 0; i < 16 && q.size() != 0; i++) @(posedge clk);
        #1; n_vec++;
        if (q.size() != 0) begin n_err++; $display("FAIL rstmid_drain: %0d outputs missing, required 0", q.size()); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp1, expf;
        int          seen;
`ifdef COS_PROJ_ACCUM_SAT_EN
        exp1 = 32'h7FFFFFFF; expf = 32'h7FFFFFFF;
`else
        exp1 = 32'hFFFFFFFE; expf = 32'hFFFFFF60;
`endif
        seen = 0;
        for (int i = 0; i < FL + 5; i++) begin
            vld_b  = (i < FL);
            data_b = 32'h7FFFFFFF;
            @(posedge clk); #1;
            vld_b = 1'b0;
            if (ov_b === 1'b1 && addr_b == 8'd0) begin
                n_vec++;
                if (sums_b[31:0] !== 32'h7FFFFFFF || ovf_b[0] !== 1'b0) begin
                    n_err++; $display("FAIL ovf_k0: got ch0=%h ovf0=%b, required 7fffffff/0", sums_b[31:0], ovf_b[0]);
                end
            end
            if (ov_b === 1'b1 && addr_b == 8'd1) begin
                n_vec++;
                if (sums_b[31:0] !== exp1 || ovf_b[0] !== 1'b1) begin
                    n_err++; $display("FAIL ovf_k1: got ch0=%h ovf0=%b, required %h/1", sums_b[31:0], ovf_b[0], exp1);
                end
            end
            if (done_b === 1'b1) begin
                seen++;
                n_vec++;
                if (sums_b[31:0] !== expf || ovf_b[0] !== 1'b1 || addr_b !== 8'd159) begin
                    n_err++; $display("FAIL ovf_last: got ch0=%h ovf0=%b addr=%0d, required %h/1/159", sums_b[31:0], ovf_b[0], addr_b, expf);
                end
            end
        end
        n_vec++;
        if (seen != 1) begin n_err++; $display("FAIL ovf_done_count: got %0d frame_done pulses, required 1", seen); end
    endtask

    initial begin
        for (int i = 0; i < TL; i++) begin
            cos_tab[i] = longint'($cos(2.0 * PI * real'(i) / real'(TL)) * 1073741824.0);
        end
        test_reset();
        test_single_frame();
        test_gap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cos_proj_accum.md
COS_PROJ_ACCUM -- requirements
Module: cos_proj_accum

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, meaning the sample, cosine and accumulator width.
REQ-002 SHALL have parameter FRAME_LEN, default 160, meaning the number of valid samples per frame.
REQ-003 SHALL have parameter NUM_NU, default 3, meaning the number of cosine channels; channel n uses harmonic n, for n = 0..NUM_NU-1.
REQ-004 SHALL have parameter TABLE_LEN, default 512 (power of 2), meaning the number of cosine table entries over one full period.
REQ-005 SHALL have parameter SCALE_SHIFT, default 4, meaning the extra right shift applied to each product for headroom.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_in, input, 1 bit: synchronous reset, active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data holds a sample this cycle.
REQ-009 SHALL have port in_data, input, BIT_WIDTH bits: signed sample.
REQ-010 SHALL have port frame_abort, input, 1 bit: discard the current frame.
REQ-011 SHALL have port out_sums, output, NUM_NU*BIT_WIDTH bits: packed signed prefix sums, with channel n at bits [n*BIT_WIDTH +: BIT_WIDTH].
REQ-012 SHALL have port out_valid, output, 1 bit: out_sums and out_addr are valid this cycle.
REQ-013 SHALL have port out_addr, output, $clog2(FRAME_LEN) bits: sample index k of the output.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the output for k = FRAME_LEN-1.
REQ-015 SHALL have port overflow, output, NUM_NU bits: per-channel sticky overflow flag for the current frame.

Function
REQ-016 SHALL count accepted samples: k = 0 for the first in_valid sample of a frame, incremented on each later in_valid sample.
REQ-017 SHALL treat in_valid-low cycles inside a frame as gaps: k and the accumulators hold, and there is no output for those cycles.
REQ-018 SHALL use cosine value cos_n(k) = table[(n*k) mod TABLE_LEN], where the table is signed Q2.(BIT_WIDTH-2), so 1.0 = 2^(BIT_WIDTH-2).
REQ-019 SHALL form product p_n = (in_data * cos_n(k)) computed at full 2*BIT_WIDTH precision, arithmetic-shifted right by (BIT_WIDTH-2+SCALE_SHIFT), then truncated to BIT_WIDTH.
REQ-020 SHALL output the prefix sum S_n(k) = sum over j=0..k of p_n(j) exactly 3 cycles after the cycle in which sample k was accepted (stages: ROM read, multiply, accumulate).
REQ-021 SHALL clear all accumulators and set k to 0 after the sample with k = FRAME_LEN-1, so the next sample starts a new frame with no idle cycle needed; back-to-back frames SHALL be supported at full rate.
REQ-022 SHALL respond to frame_abort by clearing k, the accumulators and overflow, and by suppressing out_valid for all in-flight samples; a sample presented in the same cycle as frame_abort SHALL be accepted as k = 0 of a new frame.
REQ-023 SHALL drive out_sums to 0 while out_valid is low.
REQ-024 SHALL set overflow[n] on any signed overflow of the channel-n addition, hold it until frame start, abort or reset, and clear it coincident with the first output of the next frame.

Reset
REQ-025 SHALL, on rst_in high at a clock edge, set out_valid, frame_done, out_addr, out_sums, overflow, k, the accumulators and all pipeline valid bits to 0.
REQ-026 SHALL discard any in-flight samples when reset is asserted mid-frame; the first sample accepted after reset is k = 0.

Configuration
REQ-027 SHALL, when macro COS_PROJ_ACCUM_SAT_EN is defined, saturate each accumulator addition to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
REQ-028 SHALL, without COS_PROJ_ACCUM_SAT_EN, let accumulator additions wrap two's-complement; overflow SHALL be reported in both builds.

Structure
REQ-029 SHALL take TABLE_LEN, the Q-format constant and the saturation limit functions from the shared package cos_proj_pkg.
REQ-030 SHALL instantiate one sub-module, cos_rom_multiport, providing NUM_NU registered read ports from a single cosine table with 1-cycle latency.

Verification
REQ-031 SHALL be covered by a bench case: BIT_WIDTH=32, in_data=65536 for 160 consecutive cycles -> channel 0 gives out_sums=4096*(k+1) at each k, reaching 655360 at k=159 with frame_done high in that cycle only, 3 cycles after the last sample.
REQ-032 SHALL be covered by a bench case: the same stream with in_valid low for 5 cycles after k=40 -> identical out_sums sequence, with no output during the gap and out_addr continuous.
REQ-033 SHALL be covered by a bench case: frame_abort at k=80 together with a new sample -> no outputs for k=78..80 of the old frame; the new frame's first output has out_addr=0 and out_sums ch0=4096.
REQ-034 SHALL be covered by a bench case: in_data=0x7FFFFFFF for 160 samples with SCALE_SHIFT=0 -> with COS_PROJ_ACCUM_SAT_EN, ch0 clamps at 0x7FFFFFFF and overflow[0]=1; without it, the value wraps negative and overflow[0]=1.
REQ-035 SHALL be covered by a bench case: two back-to-back 160-sample frames -> the second frame restarts at out_addr=0 with sums not carrying over and overflow cleared.
REQ-036 SHALL be covered by a bench case: rst_in pulsed at k=100 -> outputs 0 the next cycle, no stale out_valid, and the next sample gives out_addr=0.
